// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES inverse cipher.
// Reduction polynomial is 0x11B throughout.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    // Byte 0 sits at bit 0; bytes fill the state column by column.
    typedef logic [0:AES_BLK_W-1] block_t;

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} dec_state_e;

    // Output byte i of InvShiftRows is taken from input byte INV_SR[i].
    localparam int INV_SR [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Column bytes are row 0 in [31:24] down to row 3 in [7:0].
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext ingress, key-RAM read port and plaintext egress of the inverse cipher.
// The slave modport is the cipher side; master is the surrounding system.
interface aes_inv_cipher_iter_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    block_t     ct;
    logic       key_rd_en;
    logic [3:0] key_rd_idx;
    block_t     key_rd_data;
    logic       out_valid;
    logic       out_ready;
    block_t     pt;

    modport slave (
        input  in_valid, ct, key_rd_data, out_ready,
        output in_ready, key_rd_en, key_rd_idx, out_valid, pt
    );

    modport master (
        output in_valid, ct, key_rd_data, out_ready,
        input  in_ready, key_rd_en, key_rd_idx, out_valid, pt
    );
endinterface

// File: rtl/aes_inv_cipher_iter_inv_sbox.sv
// Combinational AES inverse S-box for a single byte.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    assign out_o = INV_SBOX[in_i];
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption, one round per clock, round keys fetched NR..0 from key RAM.
// Define AES_DEC_ZEROIZE_EN to clear state, latched ciphertext and plaintext on egress handshake.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_inv_cipher_iter_if.slave  bus
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX = 4'(NR);

    dec_state_e state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    block_t     ct_q, ct_d;
    block_t     st_q, st_d;
    block_t     pt_q, pt_d;
    logic       out_valid_q, out_valid_d;

    logic       in_ready_c;
    logic       key_rd_en_c;
    logic [3:0] key_rd_idx_c;
    block_t     sr_w, sub_w, mix_w;

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign sr_w[8*i +: 8] = st_q[8*INV_SR[i] +: 8];
        aes_inv_sbox u_sbox (
            .in_i  (sr_w[8*i +: 8]),
            .out_o (sub_w[8*i +: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mix_w[32*c +: 32] = inv_mix_col(sub_w[32*c +: 32] ^ bus.key_rd_data[32*c +: 32]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            ct_q        <= '0;
            st_q        <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            ct_q        <= ct_d;
            st_q        <= st_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ingress outputs are gated by rst_n so they read 0 while reset is held.
    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        ct_d         = ct_q;
        st_d         = st_q;
        pt_d         = pt_q;
        out_valid_d  = out_valid_q;
        in_ready_c   = 1'b0;
        key_rd_en_c  = 1'b0;
        key_rd_idx_c = '0;
        case (state_q)
            IDLE: begin
                in_ready_c   = rst_n;
                key_rd_en_c  = bus.in_valid & rst_n;
                key_rd_idx_c = rst_n ? NR_IDX : 4'd0;
                if (bus.in_valid && rst_n) begin
                    ct_d    = bus.ct;
                    state_d = INIT;
                end
            end
            INIT: begin
                st_d         = ct_q ^ bus.key_rd_data;
                key_rd_en_c  = 1'b1;
                key_rd_idx_c = NR_IDX - 4'd1;
                rnd_d        = NR_IDX - 4'd1;
                state_d      = ROUND;
            end
            ROUND: begin
                st_d         = mix_w;
                key_rd_en_c  = 1'b1;
                key_rd_idx_c = rnd_q - 4'd1;
                rnd_d        = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                pt_d        = sub_w ^ bus.key_rd_data;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef AES_DEC_ZEROIZE_EN
                    st_d        = '0;
                    ct_d        = '0;
                    pt_d        = '0;
`else
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.key_rd_en  = key_rd_en_c;
    assign bus.key_rd_idx = key_rd_idx_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.pt         = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed self-checking bench for aes_inv_cipher_iter (NR=10) using FIPS-197 vectors,
// a behavioural key RAM with one-cycle read latency, and the optional zeroize build.
module tb_aes_inv_cipher_iter;
    import aes_pkg::*;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_cipher_iter_if busIf ();

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    block_t     keyRam [16];
    logic [7:0] fwdSbox [256];
    logic [3:0] idxLog [$];
    int         cycleCount = 0;
    int         startCycle = 0;
    int         totalCount = 0;
    int         badCount = 0;

    // Key RAM: data appears the cycle after the strobe; every strobe is logged.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (busIf.key_rd_en) begin
            busIf.key_rd_data <= keyRam[busIf.key_rd_idx];
            idxLog.push_back(busIf.key_rd_idx);
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // AES-128 key expansion into keyRam[0..10].
    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {fwdSbox[t[23:16]], fwdSbox[t[15:8]], fwdSbox[t[7:0]], fwdSbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) keyRam[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input string tag, input logic [127:0] ctVal);
        int guard;
        guard = 0;
        while (!busIf.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_inReadyWait"}, 128'(busIf.in_ready), 128'd1);
        idxLog.delete();
        busIf.ct       = ctVal;
        busIf.in_valid = 1'b1;
        startCycle     = cycleCount;
        @(negedge clk);
        busIf.in_valid = 1'b0;
        busIf.ct       = '0;
    endtask

    task automatic waitOutput(input string tag, input logic [127:0] expPt);
        int guard;
        logic [127:0] seen, want;
        guard = 0;
        while (!busIf.out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_latency"}, 128'(cycleCount - startCycle), 128'd12);
        checkOutput({tag, "_pt"}, busIf.pt, expPt);
        checkOutput({tag, "_keyEnDone"}, 128'(busIf.key_rd_en), 128'd0);
        seen = '0;
        want = '0;
        for (int k = 0; k < 11; k++) begin
            want[4*k +: 4] = 4'(10 - k);
            seen[4*k +: 4] = (k < idxLog.size()) ? idxLog[k] : 4'hf;
        end
        checkOutput({tag, "_idxSeq"}, seen, want);
        checkOutput({tag, "_nReads"}, 128'(idxLog.size()), 128'd11);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] holdPt;
        logic         sawValid;
        logic [127:0] zeroizeExp;

        busIf.in_valid  = 1'b0;
        busIf.ct        = '0;
        busIf.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) fwdSbox[INV_SBOX[i]] = 8'(i);
        for (int i = 0; i < 16; i++) keyRam[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_inReady", 128'(busIf.in_ready), 128'd0);
        checkOutput("rst_keyEn", 128'(busIf.key_rd_en), 128'd0);
        checkOutput("rst_keyIdx", 128'(busIf.key_rd_idx), 128'd0);
        checkOutput("rst_outValid", 128'(busIf.out_valid), 128'd0);
        checkOutput("rst_pt", busIf.pt, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_inReady", 128'(busIf.in_ready), 128'd1);

        $display("[TB] FIPS-197 App. B vector with backpressure");
        expandKey(KEY_B);
        applyStimulus("appB", CT_B);
        waitOutput("appB", PT_B);
        holdPt = busIf.pt;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_pt", busIf.pt, PT_B);
            checkOutput("bp_inReady", 128'(busIf.in_ready), 128'd0);
            checkOutput("bp_outValid", 128'(busIf.out_valid), 128'd1);
            @(negedge clk);
        end
        checkOutput("bp_ptHold", busIf.pt, holdPt);
        busIf.out_ready = 1'b1;
        @(negedge clk);
        busIf.out_ready = 1'b0;
        checkOutput("hs_inReady", 128'(busIf.in_ready), 128'd1);
        checkOutput("hs_outValid", 128'(busIf.out_valid), 128'd0);
`ifdef AES_DEC_ZEROIZE_EN
        zeroizeExp = '0;
`else
        zeroizeExp = PT_B;
`endif
        checkOutput("hs_ptAfter", busIf.pt, zeroizeExp);

        $display("[TB] FIPS-197 C.1 vector with stray in_valid during rounds");
        expandKey(KEY_C);
        applyStimulus("c1", CT_C);
        repeat (3) @(negedge clk);
        busIf.ct        = CT_B;
        busIf.in_valid  = 1'b1;
        busIf.out_ready = 1'b1;
        checkOutput("c1_busyInReady", 128'(busIf.in_ready), 128'd0);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        busIf.ct       = '0;
        checkOutput("c1_earlyOutValid", 128'(busIf.out_valid), 128'd0);
        waitOutput("c1", PT_C);
        @(negedge clk);
        busIf.out_ready = 1'b0;
        checkOutput("c1_hsOutValid", 128'(busIf.out_valid), 128'd0);
        checkOutput("c1_hsInReady", 128'(busIf.in_ready), 128'd1);

        $display("[TB] reset asserted mid-block");
        expandKey(KEY_B);
        applyStimulus("mid", CT_B);
        repeat (4) @(negedge clk);
        checkOutput("mid_keyEnBefore", 128'(busIf.key_rd_en), 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_outValid", 128'(busIf.out_valid), 128'd0);
        checkOutput("mid_keyEn", 128'(busIf.key_rd_en), 128'd0);
        checkOutput("mid_pt", busIf.pt, 128'd0);
        checkOutput("mid_inReady", 128'(busIf.in_ready), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (busIf.out_valid) sawValid = 1'b1;
        end
        checkOutput("mid_noOutValid", 128'(sawValid), 128'd0);
        applyStimulus("post", CT_B);
        waitOutput("post", PT_B);
        busIf.out_ready = 1'b1;
        @(negedge clk);
        busIf.out_ready = 1'b0;
        checkOutput("post_hsInReady", 128'(busIf.in_ready), 128'd1);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
